// File: rtl/cv32e40p_x_alu_coproc.sv
// Integer coprocessor on the X-interface responder side: decodes CUSTOM-0 ops,
// computes in one registered stage, returns results via a response FIFO.
// Optional: CV32E40P_X_COPROC_ERR_EN enables signed-overflow error reporting.
module cv32e40p_x_alu_coproc #(
    parameter int unsigned DEPTH  = 2,
    parameter logic [6:0]  OPCODE = 7'b0001011
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              x_valid_i,
    output logic              x_ready_o,
    input  logic [31:0]       x_instr_data_i,
    input  logic [2:0][31:0]  x_rs_i,
    input  logic [2:0]        x_rs_valid_i,
    input  logic              x_rd_clean_i,
    output logic              x_accept_o,
    output logic              x_is_mem_op_o,
    output logic              x_writeback_o,
    output logic              x_rvalid_o,
    input  logic              x_rready_i,
    output logic [4:0]        x_rd_o,
    output logic [31:0]       x_data_o,
    output logic              x_dualwb_o,
    output logic              x_type_o,
    output logic              x_error_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] rs1, rs2, rs3;
    logic        accept, ops_ok, full, hs, load, push, pop;
    logic [31:0] sum_ab, sum_abc, res;
    logic [5:0]  pc;
    logic [CW:0] occ;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] wptr_q, rptr_q;
    logic        stg_v_q;
    logic [4:0]  stg_rd_q;
    logic [31:0] stg_data_q;
    logic [4:0]  mem_rd_q   [DEPTH];
    logic [31:0] mem_data_q [DEPTH];
    logic        unused_instr;

    assign opcode = x_instr_data_i[6:0];
    assign rd     = x_instr_data_i[11:7];
    assign funct3 = x_instr_data_i[14:12];
    assign rs1    = x_rs_i[0];
    assign rs2    = x_rs_i[1];
    assign rs3    = x_rs_i[2];
    assign unused_instr = ^x_instr_data_i[31:15];

    assign accept = (opcode == OPCODE) && (funct3 <= 3'b101);

    always_comb begin
        ops_ok = 1'b0;
        case (funct3)
            3'b100:  ops_ok = x_rs_valid_i[0];
            3'b101:  ops_ok = &x_rs_valid_i;
            default: ops_ok = &x_rs_valid_i[1:0];
        endcase
    end

    // Occupancy includes the in-flight stage; same-cycle pops are not credited.
    assign occ  = {1'b0, cnt_q} + {{CW{1'b0}}, stg_v_q};
    assign full = (occ >= DEPTH_W);

    always_comb begin
        x_ready_o = 1'b0;
        if (rst_i)       x_ready_o = 1'b0;
        else if (!accept) x_ready_o = 1'b1;
        else             x_ready_o = ops_ok && x_rd_clean_i && !full;
    end

    assign x_accept_o    = !rst_i && accept;
    assign x_writeback_o = !rst_i && accept && (rd != 5'd0);
    assign x_is_mem_op_o = 1'b0;
    assign x_dualwb_o    = 1'b0;
    assign x_type_o      = 1'b0;

    assign hs   = x_valid_i && x_ready_o;
    assign load = hs && accept && (rd != 5'd0);

    assign sum_ab  = rs1 + rs2;
    assign sum_abc = sum_ab + rs3;

    always_comb begin
        pc = '0;
        for (int i = 0; i < 32; i++) pc = pc + {5'd0, rs1[i]};
    end

    always_comb begin
        res = '0;
        case (funct3)
            3'b000:  res = sum_ab;
            3'b001:  res = rs1 ^ rs2;
            3'b010:  res = ($signed(rs1) < $signed(rs2)) ? rs1 : rs2;
            3'b011:  res = (rs1 > rs2) ? rs1 : rs2;
            3'b100:  res = {26'd0, pc};
            3'b101:  res = sum_abc;
            default: res = '0;
        endcase
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // The stage drains into the FIFO every cycle; admission guarantees room.
    assign push  = stg_v_q;
    assign pop   = x_rvalid_o && x_rready_i;
    assign cnt_d = cnt_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stg_v_q    <= 1'b0;
            stg_rd_q   <= '0;
            stg_data_q <= '0;
            cnt_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            stg_v_q <= load;
            if (load) begin
                stg_rd_q   <= rd;
                stg_data_q <= res;
            end
            cnt_q <= cnt_d;
            if (push) wptr_q <= ptr_inc(wptr_q);
            if (pop)  rptr_q <= ptr_inc(rptr_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_rd_q[wptr_q]   <= stg_rd_q;
            mem_data_q[wptr_q] <= stg_data_q;
        end
    end

    assign x_rvalid_o = (cnt_q != '0);
    assign x_rd_o     = x_rvalid_o ? mem_rd_q[rptr_q] : 5'd0;
    assign x_data_o   = x_rvalid_o ? mem_data_q[rptr_q] : 32'd0;

`ifdef CV32E40P_X_COPROC_ERR_EN
    logic ovf_ab, ovf_abc, err_d, stg_err_q;
    logic mem_err_q [DEPTH];

    assign ovf_ab  = (rs1[31] == rs2[31]) && (sum_ab[31] != rs1[31]);
    assign ovf_abc = (sum_ab[31] == rs3[31]) && (sum_abc[31] != sum_ab[31]);
    assign err_d   = ((funct3 == 3'b000) && ovf_ab) ||
                     ((funct3 == 3'b101) && (ovf_ab || ovf_abc));

    always_ff @(posedge clk_i) begin
        if (rst_i)     stg_err_q <= 1'b0;
        else if (load) stg_err_q <= err_d;
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_err_q[wptr_q] <= stg_err_q;
    end

    assign x_error_o = x_rvalid_o ? mem_err_q[rptr_q] : 1'b0;
`else
    assign x_error_o = 1'b0;
`endif

endmodule

// File: doc/cv32e40p_x_alu_coproc.md
Name: cv32e40p_x_alu_coproc

Overview:
Minimal integer coprocessor on the responder end of the cv32e40p X-interface. It decodes offloaded CUSTOM-0 instructions and accepts or rejects them. Accepted instructions are computed in one registered stage, and results are returned to the core through a response FIFO on the X-response channel. It serves as the bench-level stand-in coprocessor for exercising the core's offload path without the FPU.

Parameters:
DEPTH, 2, response FIFO entries including the in-flight stage slot (>=1)
OPCODE, 7'b0001011, major opcode claimed by this coprocessor (CUSTOM-0)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
x_valid_i  in  1  request valid from core
x_ready_o  out  1  request ready
x_instr_data_i  in  32  offloaded instruction word
x_rs_i  in  96  rs1/rs2/rs3 operands, packed [2:0][31:0]
x_rs_valid_i  in  3  per-operand valid
x_rd_clean_i  in  1  core has no pending write to rd
x_accept_o  out  1  instruction claimed, valid while x_valid_i
x_is_mem_op_o  out  1  always 0
x_writeback_o  out  1  result will be written back
x_rvalid_o  out  1  response valid
x_rready_i  in  1  core ready for response
x_rd_o  out  5  destination register of head response
x_data_o  out  32  result of head response
x_dualwb_o  out  1  always 0
x_type_o  out  1  always 0 (integer register file)
x_error_o  out  1  response error flag

Behaviour:
- Clock and reset: one clock clk_i. Reset rst_i is synchronous and active-high.
- Reset values: x_rvalid_o=0, x_rd_o=0, x_data_o=0, x_error_o=0. The FIFO is emptied and the in-flight stage cleared. While rst_i=1, x_ready_o=0 and x_accept_o=0.
- Decode (combinational on x_instr_data_i): accept = opcode==OPCODE && funct3<=3'b101.
- Operations by funct3:
  - 000 rs1+rs2
  - 001 rs1^rs2
  - 010 signed min(rs1,rs2)
  - 011 unsigned max(rs1,rs2)
  - 100 popcount(rs1), zero-extended
  - 101 rs1+rs2+rs3
  - All sums are mod 2^32.
- Required operands:
  - 100 needs rs1 only.
  - 101 needs rs1, rs2 and rs3.
  - All other operations need rs1 and rs2.
- x_accept_o = accept. x_writeback_o = accept && rd!=0. x_is_mem_op_o=0.
- Handshake: a transfer occurs when x_valid_i && x_ready_o.
  - Rejected instructions: x_ready_o=1 immediately. No response is generated.
  - Accepted instructions: x_ready_o=1 only when all required x_rs_valid_i bits are 1, x_rd_clean_i=1, and occupancy<DEPTH.
- Occupancy counts FIFO entries plus the in-flight stage. A pop in the same cycle does not free a slot for that cycle's request (no bypass).
- Accepted with rd==0: the handshake completes, nothing is computed or pushed, and no response is returned.
- Latency: a handshake in cycle N loads the stage register. The result enters the FIFO at the edge ending cycle N+1. x_rvalid_o is 1 no earlier than cycle N+2, and exactly N+2 when the FIFO was empty.
- Response: x_rvalid_o = FIFO not empty. x_rd_o, x_data_o and x_error_o reflect the head entry and are held stable while x_rvalid_o && !x_rready_i. The entry pops when x_rvalid_o && x_rready_i.
- Ordering: responses are returned strictly in acceptance order.
- Empty FIFO: x_rd_o, x_data_o and x_error_o read 0.
- Back-to-back accepts are sustained at one per cycle while space remains.
- Simultaneous push and pop with FIFO full: legal. The count is unchanged and pointers wrap modulo DEPTH.
- Reset mid-operation: all queued and in-flight results are discarded. x_rvalid_o is 0 in the first cycle after reset deasserts.
- x_valid_i with x_ready_o=0: no state change. The core may hold or change the request.

Optional Feature:
CV32E40P_X_COPROC_ERR_EN
- Defined: funct3 000 and 101 set x_error_o=1 on signed overflow of any partial or final sum. Data is still returned, and the flag is stored per FIFO entry.
- Undefined: x_error_o is tied 0 and no overflow logic is built.

Test Plan:
- funct3=000, rs1=5, rs2=7, rd=3, x_rready_i=1 -> x_accept_o=1 and x_writeback_o=1 at handshake; two cycles later x_rvalid_o=1, x_rd_o=3, x_data_o=12.
- opcode 0110011 (OP) with x_valid_i=1 -> x_ready_o=1, x_accept_o=0; x_rvalid_o stays 0 for 10 cycles.
- funct3=101 with x_rs_valid_i=3'b011 for 3 cycles, then 3'b111; rs=1,2,3 -> x_ready_o=0 until rs3 is valid; response data=6.
- DEPTH=2, x_rready_i=0, three back-to-back accepts -> the third stalls with x_ready_o=0; raising x_rready_i returns data in order, and the third is accepted the cycle after the first pop.
- rs1=32'h7FFFFFFF, rs2=1, funct3=000 -> data=32'h80000000; x_error_o=1 only with CV32E40P_X_COPROC_ERR_EN defined.
- Two entries queued, rst_i pulsed for 1 cycle -> x_rvalid_o=0 and x_data_o=0 after reset; a new request returns only its own result.
